// File: rtl/uc_seq.sv
// uc_seq: sequenced control unit for the 16-bit single-cycle CPU.
// The control outputs are decoded combinationally from opcode, z and the FSM
// state, so the datapath stays single-cycle. Around that decode sits a small
// FSM (RUN / WAIT / HALT), a debug stall, a sticky illegal-opcode flag and a
// retired-instruction counter.
//
// Handshake: there is no valid/ready pair. pc_en is the only flow-control
// signal. When pc_en=1 the current instruction completes on the next rising
// edge and is counted in retired. When pc_en=0 the PC holds, and so does the
// instruction the datapath presents.
module uc_seq #(
  parameter int WAIT_CYCLES = 4,   // extra stall length of WAIT, 1..255
  parameter int RET_W       = 16   // width of the retired counter
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic [5:0]       opcode,
  input  logic             z,
  input  logic             stall,
  input  logic             resume,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       op_alu,
  output logic             pc_en,
  output logic             halted,
  output logic             illegal,
  output logic [RET_W-1:0] retired,
  output logic [1:0]       state_dbg   // raw FSM state, for debug and checkers
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b010000;
  localparam logic [5:0] OP_JZ   = 6'b010001;
  localparam logic [5:0] OP_JNZ  = 6'b010010;
  localparam logic [5:0] OP_HALT = 6'b010011;
  localparam logic [5:0] OP_WAIT = 6'b010100;

  // WAIT spends one cycle in RUN issuing, then counts down to zero in WAIT.
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic [RET_W-1:0]   retired_q, retired_d;

  // These are the control values before the reset override is applied.
  logic               s_inc_c, s_inm_c, we3_c, wez_c, pc_en_c;
  logic [2:0]         op_alu_c;

  // Opcode class decode.
  logic is_nop, is_li, is_alu, is_j, is_jz, is_jnz, is_halt, is_wait, is_legal;

  // Classify the opcode, independent of state.
  always_comb begin
    is_nop   = (opcode == OP_NOP);
    is_li    = (opcode[5:2] == 4'b0001);
    is_alu   = (opcode[5:3] == 3'b001);
    is_j     = (opcode == OP_J);
    is_jz    = (opcode == OP_JZ);
    is_jnz   = (opcode == OP_JNZ);
    is_halt  = (opcode == OP_HALT);
    is_wait  = (opcode == OP_WAIT);
    is_legal = is_nop | is_li | is_alu | is_j | is_jz | is_jnz | is_halt | is_wait;
  end

  // Control decode and FSM next-state logic.
  always_comb begin
    s_inc_c   = 1'b1;
    s_inm_c   = 1'b0;
    we3_c     = 1'b0;
    wez_c     = 1'b0;
    op_alu_c  = 3'b000;
    pc_en_c   = 1'b1;
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;

    if (stall) begin
      // Debug freeze: nothing advances and nothing is written. State, cnt
      // and retired hold, and an illegal opcode seen now is not recorded.
      pc_en_c = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (is_li) begin
            s_inm_c = 1'b1;
            we3_c   = 1'b1;
          end else if (is_alu) begin
            op_alu_c = opcode[2:0];
            we3_c    = 1'b1;
            wez_c    = 1'b1;
          end else if (is_j) begin
            s_inc_c = 1'b0;
          end else if (is_jz) begin
            s_inc_c = ~z;
          end else if (is_jnz) begin
            s_inc_c = z;
          end else if (is_halt) begin
            pc_en_c = 1'b0;
            state_d = ST_HALT;
          end else if (is_wait) begin
            pc_en_c = 1'b0;
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end else if (!is_legal) begin
            // Undefined opcodes act as NOP but are remembered.
            illegal_d = 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q != 8'd0) begin
            pc_en_c = 1'b0;
            cnt_d   = cnt_q - 8'd1;
          end else begin
            // Countdown done: the WAIT instruction completes this cycle.
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          if (!resume) begin
            pc_en_c = 1'b0;
          end else begin
            // Resume completes the HALT instruction and steps past it.
            state_d = ST_RUN;
          end
        end
        default: begin
          pc_en_c = 1'b0;
          state_d = ST_RUN;
        end
      endcase
    end

    // Every cycle that lets the PC advance completes an instruction.
    retired_d = pc_en_c ? (retired_q + RET_W'(1)) : retired_q;
  end

  // While reset is held, drive safe values so the datapath does nothing.
  always_comb begin
    if (!reset) begin
      s_inc  = 1'b1;
      s_inm  = 1'b0;
      we3    = 1'b0;
      wez    = 1'b0;
      op_alu = 3'b000;
      pc_en  = 1'b0;
      halted = 1'b0;
    end else begin
      s_inc  = s_inc_c;
      s_inm  = s_inm_c;
      we3    = we3_c;
      wez    = wez_c;
      op_alu = op_alu_c;
      pc_en  = pc_en_c;
      halted = (state_q == ST_HALT);
    end
  end

  // State, countdown, sticky flag and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign illegal   = illegal_q;
  assign retired   = retired_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uc_seq.sv
// Bench for uc_seq: directed per-cycle vectors with hand-written expected
// control values. A scoreboard queue holds them, and a monitor on the falling
// edge compares them against the outputs.
module tb_uc_seq;

  localparam int WAIT_CYCLES = 4;
  localparam int RET_W       = 4;
  localparam int W           = 16;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] WAITS = 2'd1;
  localparam logic [1:0] HALTS = 2'd2;

  localparam logic [5:0] NOP    = 6'b000000;
  localparam logic [5:0] LI     = 6'b000111;
  localparam logic [5:0] ALU2   = 6'b001010;
  localparam logic [5:0] ALU0   = 6'b001000;
  localparam logic [5:0] J      = 6'b010000;
  localparam logic [5:0] JZ     = 6'b010001;
  localparam logic [5:0] JNZ    = 6'b010010;
  localparam logic [5:0] HALTOP = 6'b010011;
  localparam logic [5:0] WAITOP = 6'b010100;
  localparam logic [5:0] ILL    = 6'b111111;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [5:0]       opcode = 6'd0;
  logic             z = 1'b0;
  logic             stall = 1'b0;
  logic             resume = 1'b0;
  logic             s_inc, s_inm, we3, wez, pc_en, halted, illegal;
  logic [2:0]       op_alu;
  logic [RET_W-1:0] retired;
  logic [1:0]       state_dbg;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           failures = 0;

  // Values of the registered outputs that the bench expects.
  logic [RET_W-1:0] exp_ret = '0;
  logic             exp_ill = 1'b0;

  uc_seq #(.WAIT_CYCLES(WAIT_CYCLES), .RET_W(RET_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .stall(stall),
    .resume(resume), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
    .op_alu(op_alu), .pc_en(pc_en), .halted(halted), .illegal(illegal),
    .retired(retired), .state_dbg(state_dbg)
  );

  // Clock: 10 time units, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Monitor: compare outputs on the falling edge against queued expectations.
  always @(negedge clk) begin
    logic [W-1:0] got, e;
    string        nm;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {pc_en, s_inc, s_inm, we3, wez, op_alu, halted, illegal, retired, state_dbg};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got pc_en,s_inc,s_inm,we3,wez,op_alu,halted,illegal,retired,state=%b_%b_%b_%b_%b_%b_%b_%b_%h_%h expected %b_%b_%b_%b_%b_%b_%b_%b_%h_%h",
                 nm, got[15], got[14], got[13], got[12], got[11], got[10:8], got[7], got[6], got[5:2], got[1:0],
                 e[15], e[14], e[13], e[12], e[11], e[10:8], e[7], e[6], e[5:2], e[1:0]);
      end
    end
  end

  // Drive one cycle just after a rising edge and queue the expected outputs.
  task automatic step(input string nm, input logic rst, input logic [5:0] op,
                      input logic zz, input logic st_in, input logic res,
                      input logic e_pc, input logic e_inc, input logic e_inm,
                      input logic e_we, input logic e_wez, input logic [2:0] e_alu,
                      input logic e_h, input logic [1:0] e_st, input logic set_ill);
    @(posedge clk);
    #1;
    reset  = rst;
    opcode = op;
    z      = zz;
    stall  = st_in;
    resume = res;
    if (!rst) begin
      exp_ret = '0;
      exp_ill = 1'b0;
    end
    exp_q.push_back({e_pc, e_inc, e_inm, e_we, e_wez, e_alu, e_h, exp_ill, exp_ret, e_st});
    name_q.push_back(nm);
    if (rst && e_pc) exp_ret = exp_ret + 4'd1;
    if (set_ill) exp_ill = 1'b1;
  endtask

  // One ordinary instruction in RUN with no stall; the PC advances.
  task automatic run_op(input string nm, input logic [5:0] op, input logic zz,
                        input logic e_inc, input logic e_inm, input logic e_we,
                        input logic e_wez, input logic [2:0] e_alu);
    step(nm, 1'b1, op, zz, 1'b0, 1'b0, 1'b1, e_inc, e_inm, e_we, e_wez, e_alu, 1'b0, RUN, 1'b0);
  endtask

  initial begin
    // Reset held for 3 cycles: every output is forced.
    repeat (3) step("reset_hold", 1'b0, ALU2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b0);

    // Basic decode.
    run_op("alu_010", ALU2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010);
    run_op("jz_z1",   JZ,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    run_op("jz_z0",   JZ,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    run_op("jnz_z1",  JNZ,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    run_op("jnz_z0",  JNZ,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    run_op("j_z1",    J,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    run_op("j_z0",    J,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    run_op("li",      LI,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    run_op("nop",     NOP,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);

    // A stalled illegal opcode must neither retire nor set the flag.
    step("stall_ill", 1'b1, ILL, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b0);
    run_op("after_stall", NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);

    // WAIT: 4 cycles with pc_en=0, then pc_en=1 on the 5th.
    step("wait_issue", 1'b1, WAITOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b0);
    repeat (3) step("wait_cnt", 1'b1, WAITOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, WAITS, 1'b0);
    step("wait_done", 1'b1, WAITOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, WAITS, 1'b0);
    run_op("after_wait", NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);

    // WAIT with 2 stalled cycles mid-count: 7 cycles in total.
    step("wst_issue", 1'b1, WAITOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b0);
    step("wst_cnt", 1'b1, WAITOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, WAITS, 1'b0);
    repeat (2) step("wst_stall", 1'b1, WAITOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, WAITS, 1'b0);
    repeat (2) step("wst_cnt2", 1'b1, WAITOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, WAITS, 1'b0);
    step("wst_done", 1'b1, WAITOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, WAITS, 1'b0);
    run_op("after_wst", NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);

    // Illegal opcode: NOP behaviour, then the flag is sticky.
    step("illegal_op", 1'b1, ILL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b1);
    run_op("ill_sticky", ALU0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
    run_op("ill_sticky2", LI, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);

    // HALT, resume blocked by stall, then a real resume.
    step("halt_issue", 1'b1, HALTOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b0);
    repeat (3) step("halt_hold", 1'b1, HALTOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, HALTS, 1'b0);
    step("halt_res_stall", 1'b1, HALTOP, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, HALTS, 1'b0);
    step("halt_resume", 1'b1, HALTOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, HALTS, 1'b0);
    step("res_in_run", 1'b1, NOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b0);

    // Counter wrap: after reset, 17 NOPs leave retired at 1 (RET_W=4).
    step("wrap_rst", 1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b0);
    repeat (17) run_op("wrap_nop", NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    run_op("wrap_chk", ALU2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010);

    // Reset dropped mid-cycle while in WAIT: state and outputs change before the next edge.
    step("aw_issue", 1'b1, WAITOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b0);
    step("aw_cnt", 1'b1, WAITOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, WAITS, 1'b0);
    step("async_rst_wait", 1'b0, WAITOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b0);

    // The same check from HALT.
    step("ah_issue", 1'b1, HALTOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b0);
    step("ah_hold", 1'b1, HALTOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, HALTS, 1'b0);
    step("async_rst_halt", 1'b0, HALTOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, RUN, 1'b0);
    run_op("post_rst", NOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    run_op("post_rst2", J, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

    // Drain the scoreboard.
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uc_seq.md
Name: uc_seq

Overview:
Sequenced control unit for the 16-bit single-cycle CPU. It sits directly upstream of the datapath, which gives it opcode (INST[15:10]) and the registered zero flag z. It returns s_inc, s_inm, we3, wez, op_alu and a PC enable.
- Beyond plain decode it holds a small FSM: multi-cycle WAIT, HALT/resume, and an external debug stall.
- It also keeps an illegal-opcode sticky flag and a retired-instruction counter.
- The datapath PC register takes pc_en as its load enable. When pc_en=0 the PC holds.

Parameters:
WAIT_CYCLES, 4, extra stall length of the WAIT instruction; legal range 1..255.
RET_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 = in reset.
opcode  input  6  current instruction opcode from the datapath.
z  input  1  registered zero flag from the datapath.
stall  input  1  debug freeze request, level-sensitive.
resume  input  1  leave HALT, sampled on clk.
s_inc  output  1  1 = PC+1, 0 = jump target INST[9:0].
s_inm  output  1  1 = write immediate, 0 = write ALU result.
we3  output  1  register file write enable.
wez  output  1  zero flag write enable.
op_alu  output  3  ALU operation.
pc_en  output  1  PC register load enable.
halted  output  1  1 while FSM is in HALT.
illegal  output  1  sticky: an undefined opcode was executed.
retired  output  RET_W  count of completed instructions, wraps modulo 2^RET_W.

Behaviour:
- Registers: state (RUN, WAIT, HALT), cnt[7:0], illegal, retired.
- On reset=0, asynchronously: state=RUN, cnt=0, illegal=0, retired=0.
- While reset=0, all outputs are forced: pc_en=0, we3=0, wez=0, s_inc=1, s_inm=0, op_alu=0, halted=0.
- Control outputs are combinational from opcode, z and state, so the datapath stays single-cycle. halted is decoded from state.
- Defaults: s_inc=1, s_inm=0, we3=0, wez=0, op_alu=3'b000, pc_en=1.
- Decode in RUN with stall=0:
  - 000000 NOP: defaults.
  - 0001xx LI: s_inm=1, we3=1.
  - 001xxx ALU: op_alu=opcode[2:0], we3=1, wez=1.
  - 010000 J: s_inc=0.
  - 010001 JZ: s_inc=~z.
  - 010010 JNZ: s_inc=z.
  - 010011 HALT: pc_en=0; next state HALT.
  - 010100 WAIT: pc_en=0; cnt<=WAIT_CYCLES-1; next state WAIT.
  - Any other opcode: NOP behaviour, and illegal<=1 (held until reset).
- retired increments on every edge where state=RUN, stall=0, pc_en=1. HALT and WAIT are counted when they complete (see below).
- WAIT state:
  - cnt!=0: pc_en=0, writes 0, cnt decrements.
  - cnt==0: pc_en=1, s_inc=1, retired++, next state RUN.
  - Total WAIT instruction time = WAIT_CYCLES+1 cycles with stall=0.
- HALT state:
  - pc_en=0, writes 0, halted=1.
  - resume=1 and stall=0: pc_en=1, s_inc=1, retired++, next state RUN.
  - resume is ignored in RUN and WAIT.
- stall=1 in any state:
  - pc_en=0, we3=0, wez=0.
  - state, cnt and retired frozen; the illegal flag is not set.
  - stall has priority over resume and over WAIT completion.
- Counter wrap: retired at 2^RET_W-1 rolls over to 0 with no flag.
- Reset mid-WAIT or mid-HALT: returns to RUN with cnt=0; the PC is reset by the datapath.

Test Plan:
- Reset then decode: hold reset=0 3 cycles -> pc_en=0, we3=0, retired=0. Release; opcode=001010 -> op_alu=010, we3=1, wez=1, s_inc=1, pc_en=1; retired=1 after the edge.
- Jumps:
  - JZ with z=1 -> s_inc=0. JZ with z=0 -> s_inc=1.
  - JNZ with z=1 -> s_inc=1. J -> s_inc=0 regardless of z.
  - LI (000111) -> s_inm=1, we3=1, wez=0.
- WAIT with WAIT_CYCLES=4: opcode=010100 -> pc_en=0 for exactly 4 cycles, pc_en=1 on the 5th, then state RUN. Asserting stall for 2 cycles mid-count stretches the total to 7 cycles.
- HALT: opcode=010011 -> halted=1 next cycle, pc_en=0 indefinitely.
  - resume with stall=1 -> stays halted.
  - resume with stall=0 -> pc_en=1 that cycle, halted=0 after the edge, retired +1.
- Illegal: opcode=111111 -> we3=0, wez=0, pc_en=1, illegal=1 after the edge. It stays 1 through later legal opcodes and clears only on reset=0.
- Wrap and async reset: RET_W=4, run 17 NOPs -> retired=1. Pull reset low mid-clock-period in WAIT -> state=RUN and outputs forced immediately, without waiting for an edge.
